lsu_bus_ctrl: RTL

Memory-stage load/store engine that consumes the decoded access enables (lb/lh/lw/lbu/lhu, sb/sh/sw) from the control path. It turns them into word-aligned transactions on a req/ack data-memory bus, stalling the pipeline until the access completes. It generates byte masks, shifts store data and aligns/extends load data. Misaligned accesses are split into two bus beats when enabled.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_ld_align.sv | 25 ++
 rtl/lsu_bus_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller.
// Build option: LSU_MISALIGN_SPLIT_EN (consumed by lsu_bus_ctrl).
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [3:0] BMASK_B = 4'b0001;
    localparam logic [3:0] BMASK_H = 4'b0011;
    localparam logic [3:0] BMASK_W = 4'b1111;

    function automatic logic [3:0] base_mask(input lsu_size_e sz);
        case (sz)
            SZ_B:    return BMASK_B;
            SZ_H:    return BMASK_H;
            default: return BMASK_W;
        endcase
    endfunction

    // Byte-lane mask widened to a 32-bit bit mask.
    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load-data alignment: shift the (up to two) read words down by the byte
// offset, truncate to the access size and sign- or zero-extend.
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [1:0]  i_off,
    input  lsu_size_e   i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] shifted;

    assign shifted = 32'(i_data >> {i_off, 3'b000});

    always_comb begin
        case (i_size)
            SZ_B:    o_data = {{24{i_signed & shifted[7]}}, shifted[7:0]};
            SZ_H:    o_data = {{16{i_signed & shifted[15]}}, shifted[15:0]};
            default: o_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Memory-stage load/store engine driving a req/ack word bus.
// Build option: LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two beats.
module lsu_bus_ctrl
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lb_en,
    input  logic        i_lh_en,
    input  logic        i_lw_en,
    input  logic        i_lbu_en,
    input  logic        i_lhu_en,
    input  logic        i_sb_en,
    input  logic        i_sh_en,
    input  logic        i_sw_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_ld_valid,
    output logic [31:0] o_ld_data,
    output logic        o_misalign,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_bmask,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_e  state_q, state_d;
    lsu_size_e   size_q, size_d;
    logic        signed_q, signed_d;
    logic        we_q, we_d;
    logic        misal_q, misal_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  mask_hi_q, mask_hi_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_bmask_q, bus_bmask_d;

    logic        any_st, any_ld, any_en;
    lsu_size_e   req_size;
    logic        req_signed;
    logic [1:0]  req_off;
    logic [7:0]  req_mask8;
    logic [63:0] req_wdata64;
    logic        req_cross;
    logic [63:0] align_in;
    logic [31:0] align_out;

    assign any_st  = i_sb_en | i_sh_en | i_sw_en;
    assign any_ld  = i_lb_en | i_lh_en | i_lw_en | i_lbu_en | i_lhu_en;
    assign any_en  = any_st | any_ld;
    assign req_off = i_addr[1:0];

    // Stores beat loads; wider beats narrower; signed beats unsigned.
    always_comb begin
        req_size   = SZ_B;
        req_signed = 1'b0;
        if (any_st) begin
            if (i_sw_en)      req_size = SZ_W;
            else if (i_sh_en) req_size = SZ_H;
        end else if (i_lw_en) begin
            req_size = SZ_W;
        end else if (i_lh_en | i_lhu_en) begin
            req_size   = SZ_H;
            req_signed = i_lh_en;
        end else begin
            req_signed = i_lb_en;
        end
    end

    assign req_mask8   = {4'b0000, base_mask(req_size)} << req_off;
    assign req_wdata64 = {32'h0, i_st_data & lane_expand(base_mask(req_size))}
                         << {req_off, 3'b000};
    assign req_cross   = |req_mask8[7:4];

    assign align_in = (state_q == BEAT2) ? {i_bus_rdata, rdata1_q} : {32'h0, i_bus_rdata};

    lsu_ld_align u_ld_align (
        .i_data   (align_in),
        .i_off    (off_q),
        .i_size   (size_q),
        .i_signed (signed_q),
        .o_data   (align_out)
    );

    always_comb begin
        // NOTE: every _d takes its _q value first so no path can infer a latch.
        state_d     = state_q;
        size_d      = size_q;
        signed_d    = signed_q;
        we_d        = we_q;
        misal_d     = misal_q;
        off_d       = off_q;
        mask_hi_d   = mask_hi_q;
        wdata_hi_d  = wdata_hi_q;
        rdata1_d    = rdata1_q;
        ld_data_d   = ld_data_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_bmask_d = bus_bmask_q;

        case (state_q)
            IDLE: begin
                if (any_en) begin
                    size_d     = req_size;
                    signed_d   = req_signed;
                    we_d       = any_st;
                    off_d      = req_off;
                    mask_hi_d  = req_mask8[7:4];
                    wdata_hi_d = req_wdata64[63:32];
                    rdata1_d   = 32'h0;
                    if (req_cross && !SPLIT_EN) begin
                        misal_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        misal_d     = 1'b0;
                        state_d     = BEAT1;
                        bus_req_d   = 1'b1;
                        bus_we_d    = any_st;
                        bus_addr_d  = {i_addr[31:2], 2'b00};
                        bus_bmask_d = req_mask8[3:0];
                        bus_wdata_d = req_wdata64[31:0];
                    end
                end
            end
            BEAT1: begin
                if (i_bus_ack) begin
                    rdata1_d = i_bus_rdata;
                    if (|mask_hi_q) begin
                        state_d     = BEAT2;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_bmask_d = mask_hi_q;
                        bus_wdata_d = wdata_hi_q;
                    end else begin
                        state_d     = DONE;
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = 32'h0;
                        bus_bmask_d = 4'h0;
                        bus_wdata_d = 32'h0;
                        if (!we_q) ld_data_d = align_out;
                    end
                end
            end
            BEAT2: begin
                if (i_bus_ack) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_bmask_d = 4'h0;
                    bus_wdata_d = 32'h0;
                    if (!we_q) ld_data_d = align_out;
                end
            end
            DONE: begin
                state_d = IDLE;
                misal_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            we_q        <= 1'b0;
            misal_q     <= 1'b0;
            off_q       <= 2'b00;
            mask_hi_q   <= 4'h0;
            wdata_hi_q  <= 32'h0;
            rdata1_q    <= 32'h0;
            ld_data_q   <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_bmask_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            we_q        <= we_d;
            misal_q     <= misal_d;
            off_q       <= off_d;
            mask_hi_q   <= mask_hi_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata1_q    <= rdata1_d;
            ld_data_q   <= ld_data_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_bmask_q <= bus_bmask_d;
        end
    end

    // Stall drops in DONE so the pipeline advances exactly once per access.
    assign o_stall     = ((state_q == IDLE) && any_en) || (state_q == BEAT1) || (state_q == BEAT2);
    assign o_ld_valid  = (state_q == DONE) && !we_q && !misal_q;
    assign o_misalign  = (state_q == DONE) && misal_q;
    assign o_ld_data   = ld_data_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_bmask = bus_bmask_q;

endmodule
